// File: rtl/counter_2.sv
// Free-running 2-bit binary up-counter built from two D flip-flops and
// gate-level next-state logic, with an asynchronous active-low clear.

module counter_2_dff (
  input  logic clock_i,
  input  logic clear_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clock_i or negedge clear_i) begin
    if (!clear_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

module counter_2 (
  input  logic       clock,
  input  logic       clear,
  output logic [1:0] state
);

  logic q0_q;
  logic q1_q;
  logic q0_d;
  logic q1_d;

  // Next state: bit 0 toggles every edge, bit 1 toggles when bit 0 is set.
  not u_not0 (q0_d, q0_q);
  xor u_xor1 (q1_d, q1_q, q0_q);

  counter_2_dff u_dff0 (
    .clock_i (clock),
    .clear_i (clear),
    .d_i     (q0_d),
    .q_o     (q0_q)
  );

  counter_2_dff u_dff1 (
    .clock_i (clock),
    .clear_i (clear),
    .d_i     (q1_d),
    .q_o     (q1_q)
  );

  assign state = {q1_q, q0_q};

endmodule

// File: tb/tb_counter_2.sv
// Bench for counter_2: directed timeline followed by randomized count/clear
// episodes, checked against an integer modulo-4 count model.

module tb_counter_2;

  logic       clock;
  logic       clear;
  logic [1:0] state;

  int unsigned passed;
  int unsigned total;
  int unsigned exp_count;

  counter_2 dut (
    .clock (clock),
    .clear (clear),
    .state (state)
  );

  initial begin
    clock = 1'b0;
    forever #10 clock = ~clock;
  end

  task automatic check(input string tag);
    logic [1:0] exp_state;
    exp_state = 2'(exp_count % 4);
    total++;
    assert (state === exp_state) passed++;
    else $error("FAIL %s at %0t: state=%b expected=%b", tag, $time, state, exp_state);
  endtask

  // Let k rising edges pass with clear high; each one adds one to the count.
  task automatic run_edges(input int k, input string tag);
    for (int i = 0; i < k; i++) begin
      @(posedge clock);
      #5;
      exp_count = (exp_count + 1) % 4;
      check(tag);
    end
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    exp_count = 0;
    clear     = 1'b0;

    // Power-up clear: the 10 ns edge must be ignored.
    #5;  check("pwr_5ns");
    #10; check("pwr_15ns");
    #3;  clear = 1'b1;              // t = 18
    #7;  check("pre_30ns");         // t = 25

    // Counting: 30 ns edge -> 01, 50 ns edge -> 10.
    #10; exp_count = 1; check("cnt_35ns");
    #20; exp_count = 2; check("cnt_55ns");

    // Asynchronous clear between edges.
    #10; clear = 1'b0;              // t = 65
    #1;  exp_count = 0; check("aclr_66ns");
    #9;  check("aclr_75ns");
    #20; check("aclr_95ns");
    #4;  clear = 1'b1;              // t = 99
    #6;  check("rel_105ns");
    #10; exp_count = 1; check("resume_115ns");

    // Second long clear: held until 500 ns across many edges.
    #6;  clear = 1'b0;              // t = 121
    #1;  exp_count = 0; check("clr2_122ns");
    while ($time < 500) begin
      @(negedge clock);
      check("clr2_hold");
    end
    clear = 1'b1;                   // t = 500, midway between edges

    // Wrap-around: 01, 10, 11, 00, 01.
    run_edges(5, "wrap");

    // Randomized episodes of counting and mid-cycle clears.
    for (int ep = 0; ep < 40; ep++) begin
      if ($urandom_range(0, 2) != 0) begin
        run_edges(int'($urandom_range(1, 7)), "rand_cnt");
      end else begin
        @(negedge clock);
        #($urandom_range(1, 8));
        clear = 1'b0;
        exp_count = 0;
        #1;
        check("rand_aclr");
        #($urandom_range(1, 45));
        check("rand_hold");
        @(negedge clock);
        #($urandom_range(1, 8));
        clear = 1'b1;
        #1;
        check("rand_rel");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
